// File: rtl/bk_adder_pipe.sv
// bk_adder_pipe: 3-stage pipelined Brent-Kung prefix adder with valid/ready flow control and tag.
// Optional macro BK_SUB_MODE_EN adds the in_sub port (A - B via inverted B and forced carry-in).
module bk_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
`ifdef BK_SUB_MODE_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LOGW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("bk_adder_pipe: WIDTH must be a power of two between 2 and 64");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("bk_adder_pipe: TAG_W must be at least 1");
  end

  // Stage registers: S1 holds per-bit g/p, S2 holds group generates, S3 holds the result.
  logic             v1_reg, v2_reg, v3_reg;
  logic [WIDTH-1:0] g1_reg, p1_reg;
  logic             c0_1_reg;
  logic [TAG_W-1:0] tag1_reg;
  logic [WIDTH-1:0] grp2_reg, p2_reg;
  logic             c0_2_reg;
  logic [TAG_W-1:0] tag2_reg;
  logic [WIDTH-1:0] sum3_reg;
  logic             cout3_reg;
  logic [TAG_W-1:0] tag3_reg;

  logic             en1, en2, en3;
  logic [WIDTH-1:0] b_eff;
  logic             c0_eff;
  logic [WIDTH-1:0] g_next, p_next;
  logic [WIDTH-1:0] grp_next, prop_tree;
  logic [WIDTH-1:0] sum_next;

  // A stage may load when it is empty or its contents move on this cycle, so bubbles collapse.
  assign en3      = !v3_reg || out_ready;
  assign en2      = !v2_reg || en3;
  assign en1      = !v1_reg || en2;
  assign in_ready = en1;

`ifdef BK_SUB_MODE_EN
  assign b_eff  = in_sub ? ~in_b : in_b;
  assign c0_eff = in_sub | in_cin;
`else
  assign b_eff  = in_b;
  assign c0_eff = in_cin;
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pg
    assign g_next[gi] = in_a[gi] & b_eff[gi];
    assign p_next[gi] = in_a[gi] ^ b_eff[gi];
  end

  // Carry-in is folded into bit 0, so every prefix G[i:0] is directly the carry into bit i+1.
  // Nodes updated within one level never feed each other, so in-place update is safe.
  always_comb begin
    grp_next    = g1_reg;
    prop_tree   = p1_reg;
    grp_next[0] = g1_reg[0] | (p1_reg[0] & c0_1_reg);
    for (int l = 0; l < LOGW; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (1 << (l + 1))) == 0) begin
          grp_next[i]  = grp_next[i] | (prop_tree[i] & grp_next[i - (1 << l)]);
          prop_tree[i] = prop_tree[i] & prop_tree[i - (1 << l)];
        end
      end
    end
    for (int l = LOGW - 2; l >= 0; l--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i >= (1 << (l + 1)))) begin
          grp_next[i]  = grp_next[i] | (prop_tree[i] & grp_next[i - (1 << l)]);
          prop_tree[i] = prop_tree[i] & prop_tree[i - (1 << l)];
        end
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum
    if (gi == 0) begin : g_lsb
      assign sum_next[gi] = p2_reg[gi] ^ c0_2_reg;
    end else begin : g_upper
      assign sum_next[gi] = p2_reg[gi] ^ grp2_reg[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg   <= 1'b0;
      g1_reg   <= '0;
      p1_reg   <= '0;
      c0_1_reg <= 1'b0;
      tag1_reg <= '0;
    end else if (en1) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        g1_reg   <= g_next;
        p1_reg   <= p_next;
        c0_1_reg <= c0_eff;
        tag1_reg <= in_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_reg   <= 1'b0;
      grp2_reg <= '0;
      p2_reg   <= '0;
      c0_2_reg <= 1'b0;
      tag2_reg <= '0;
    end else if (en2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        grp2_reg <= grp_next;
        p2_reg   <= p1_reg;
        c0_2_reg <= c0_1_reg;
        tag2_reg <= tag1_reg;
      end
    end
  end

  // Output data only changes when a new beat lands, keeping out_* steady through stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_reg    <= 1'b0;
      sum3_reg  <= '0;
      cout3_reg <= 1'b0;
      tag3_reg  <= '0;
    end else if (en3) begin
      v3_reg <= v2_reg;
      if (v2_reg) begin
        sum3_reg  <= sum_next;
        cout3_reg <= grp2_reg[WIDTH-1];
        tag3_reg  <= tag2_reg;
      end
    end
  end

  assign out_valid = v3_reg;
  assign out_sum   = sum3_reg;
  assign out_cout  = cout3_reg;
  assign out_tag   = tag3_reg;

endmodule
